core_sequencer: RTL

Fetch/decode/execute sequencer for one GPU core lane.
- Fetches 16-bit instructions from instruction memory and holds them in an instruction register that drives the instruction decoder.
- Consumes the sliced fields returned by the decoder (opcode/dest/src1/src2/imm).
- Dispatches ALU ops over a valid/ready handshake and issues register-file writebacks.
- Handles NOP, LDI, JMP, BRZ and HALT internally.

---
 rtl/core_sequencer_if.sv | 53 +++++
 rtl/core_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - bus bundle between the sequencer and its memory, decoder, ALU and register file
//
// Purpose : carries every non-clock/reset signal of core_sequencer.
// Modports: master = sequencer side, slave = environment side.
// Signals : start/base_pc (control), imem_* (fetch bus), instr_out/dec_* (decoder),
//           alu_* and rf_raddr* (ALU dispatch), rf_* (writeback), busy/done (status).
interface core_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [PC_W-1:0]   base_pc;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_data;
  logic [15:0]       instr_out;
  logic [3:0]        dec_opcode;
  logic [3:0]        dec_dest;
  logic [3:0]        dec_src1;
  logic [3:0]        dec_src2;
  logic [7:0]        dec_imm;
  logic              alu_valid;
  logic              alu_ready;
  logic [3:0]        alu_op;
  logic [3:0]        rf_raddr1;
  logic [3:0]        rf_raddr2;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_pc, imem_valid, imem_data,
    input  dec_opcode, dec_dest, dec_src1, dec_src2, dec_imm,
    input  alu_ready, alu_done, alu_result,
    output imem_req, imem_addr, instr_out,
    output alu_valid, alu_op, rf_raddr1, rf_raddr2,
    output rf_we, rf_waddr, rf_wdata, busy, done
  );

  modport slave (
    output start, base_pc, imem_valid, imem_data,
    output dec_opcode, dec_dest, dec_src1, dec_src2, dec_imm,
    output alu_ready, alu_done, alu_result,
    input  imem_req, imem_addr, instr_out,
    input  alu_valid, alu_op, rf_raddr1, rf_raddr2,
    input  rf_we, rf_waddr, rf_wdata, busy, done
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/decode/execute sequencer for one GPU core lane
//
// Purpose: fetches 16-bit instructions, holds them in the instruction register
//          for the external decoder, runs NOP/LDI/JMP/BRZ/HALT itself and hands
//          every other opcode to the ALU over a valid/ready handshake, then
//          writes the result back to the register file.
// Ports  : clk     - core clock
//          rst     - synchronous active-high reset
//          bus     - core_sequencer_if.master (control, fetch, decode, ALU, writeback, status)
module core_sequencer #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              rst,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic              zflag_q;
  logic              imem_req_q;
  logic              alu_valid_q;
  logic              rf_we_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  // Jump/branch target: the size cast truncates the 8-bit immediate when
  // PC_W < 8 and zero-extends it when PC_W > 8.
  logic [PC_W-1:0]   branch_pc;
  logic [PC_W-1:0]   pc_inc;

  assign branch_pc = PC_W'(bus.dec_imm);
  assign pc_inc    = pc_q + PC_W'(1);

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.instr_out = ir_q;
  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_op    = bus.dec_opcode;
  assign bus.rf_raddr1 = bus.dec_src1;
  assign bus.rf_raddr2 = bus.dec_src2;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= 16'h0000;
      zflag_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      alu_valid_q <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      // Fetch request and write enable are single-cycle pulses raised only
      // on the transition into FETCH / WB.
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;

      case (state_q)
        S_IDLE, S_HALTED: begin
          if (bus.start) begin
            pc_q       <= bus.base_pc;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end

        S_FETCH: state_q <= S_WAIT_MEM;

        S_WAIT_MEM: begin
          if (bus.imem_valid) begin
            ir_q    <= bus.imem_data;
            pc_q    <= pc_inc;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (bus.dec_opcode)
            OP_NOP: begin
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
            OP_LDI: begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= bus.dec_dest;
              rf_wdata_q <= DATA_W'(bus.dec_imm);
              state_q    <= S_WB;
            end
            OP_JMP: begin
              pc_q       <= branch_pc;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
            OP_BRZ: begin
              if (zflag_q) pc_q <= branch_pc;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
            OP_HALT: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_HALTED;
            end
            default: begin
              alu_valid_q <= 1'b1;
              state_q     <= S_EXEC;
            end
          endcase
        end

        // alu_op/rf_raddr* come straight from the decoder, which keeps
        // reflecting ir, so they stay stable while the request is stalled.
        S_EXEC: begin
          if (bus.alu_ready) begin
            alu_valid_q <= 1'b0;
            state_q     <= S_WAIT_ALU;
          end
        end

        S_WAIT_ALU: begin
          if (bus.alu_done) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= bus.dec_dest;
            rf_wdata_q <= bus.alu_result;
            state_q    <= S_WB;
          end
        end

        S_WB: begin
          zflag_q    <= (rf_wdata_q == '0);
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
